// File: rtl/uart_av_bridge.sv
// ---------------------------------------------------------------------------
// uart_av_bridge
//
// Debug/loader bridge: turns a byte command stream from a UART receiver into
// single-word Avalon-MM master transactions, and returns the results as a
// byte stream to a UART transmitter. One transaction in flight at a time.
//
// Command frame : opcode, 4 address bytes (LSB first), plus 4 data bytes
//                 (LSB first) for writes.
// Opcodes       : 0x52 'R' read word, 0x57 'W' write word, others -> NAK.
// Responses     : read -> 4 data bytes LSB first, write -> 0x06 (ACK),
//                 unknown opcode / bus timeout -> 0x15 (NAK).
//
// Optional feature macro: AV_BRIDGE_TIMEOUT_EN
//   Defined   : a transfer stalled for TIMEOUT_CYCLES WaitRequest cycles is
//               abandoned and answered with NAK.
//   Undefined : the bus phase waits indefinitely for WaitRequest low.
//
// Ports
//   i_Clk, i_nReset          clock, asynchronous active-low reset
//   i_RxData/i_RxValid/o_RxReady   command byte stream in (valid/ready)
//   o_TxData/o_TxValid/i_TxReady   response byte stream out (valid/ready)
//   o_AV_*  / i_AV_*         Avalon-MM master (word address, 32-bit data)
// ---------------------------------------------------------------------------
module uart_av_bridge #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_Clk,
  input  logic        i_nReset,
  input  logic [7:0]  i_RxData,
  input  logic        i_RxValid,
  output logic        o_RxReady,
  output logic [7:0]  o_TxData,
  output logic        o_TxValid,
  input  logic        i_TxReady,
  output logic [29:0] o_AV_Addr,
  output logic [3:0]  o_AV_ByteEn,
  output logic        o_AV_Read,
  output logic        o_AV_Write,
  output logic [31:0] o_AV_WriteData,
  input  logic [31:0] i_AV_ReadData,
  input  logic        i_AV_WaitRequest,
  output logic [7:0]  o_AV_BurstCount
);

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;        // frame byte index, or bytes left in RESP
  logic        is_write_reg, is_write_next;
  logic [29:0] addr_reg, addr_next;      // word address only
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] resp_reg, resp_next;      // response bytes, shifted out LSB first

  logic rx_fire;
  logic tx_fire;

  // Held low while reset is asserted even though the state is already IDLE.
  assign o_RxReady = i_nReset &&
                     ((state_reg == S_IDLE) || (state_reg == S_ADDR) || (state_reg == S_WDATA));
  assign o_TxValid = (state_reg == S_RESP);
  assign o_TxData  = resp_reg[7:0];

  // Request decoded from state, so an asynchronous reset drops it at once.
  assign o_AV_Read       = (state_reg == S_BUS) && !is_write_reg;
  assign o_AV_Write      = (state_reg == S_BUS) &&  is_write_reg;
  assign o_AV_Addr       = addr_reg;
  assign o_AV_WriteData  = wdata_reg;
  assign o_AV_ByteEn     = 4'b1111;
  assign o_AV_BurstCount = 8'd1;

  assign rx_fire = i_RxValid && o_RxReady;
  assign tx_fire = o_TxValid && i_TxReady;

`ifdef AV_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic            timeout_hit;

  // The stall cycle that would bring the count to TIMEOUT_CYCLES ends the
  // transfer, so the request is seen for exactly TIMEOUT_CYCLES stall cycles.
  assign timeout_hit = (state_reg == S_BUS) && i_AV_WaitRequest &&
                       (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_next = '0;
    if (state_reg == S_BUS && i_AV_WaitRequest) begin
      to_cnt_next = to_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_nReset) begin
    if (!i_nReset) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_next;
    end
  end
`else
  logic timeout_hit;
  assign timeout_hit = 1'b0;
`endif

  // Next-state and datapath logic.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    is_write_next = is_write_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    resp_next     = resp_reg;

    case (state_reg)
      S_IDLE: begin
        if (rx_fire) begin
          cnt_next = 2'd0;
          if (i_RxData == OP_READ) begin
            is_write_next = 1'b0;
            state_next    = S_ADDR;
          end else if (i_RxData == OP_WRITE) begin
            is_write_next = 1'b1;
            state_next    = S_ADDR;
          end else begin
            resp_next  = {24'd0, RSP_NAK};
            state_next = S_RESP;
          end
        end
      end

      S_ADDR: begin
        if (rx_fire) begin
          // Shifting the 32-bit byte address right by 8 and keeping [31:2]
          // is the same as shifting the 30-bit word address; bits [1:0]
          // simply fall off the end.
          addr_next = {i_RxData, addr_reg[29:8]};
          cnt_next  = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
            state_next = is_write_reg ? S_WDATA : S_BUS;
          end
        end
      end

      S_WDATA: begin
        if (rx_fire) begin
          wdata_next = {i_RxData, wdata_reg[31:8]};
          cnt_next   = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
            state_next = S_BUS;
          end
        end
      end

      S_BUS: begin
        if (!i_AV_WaitRequest) begin
          resp_next  = is_write_reg ? {24'd0, RSP_ACK} : i_AV_ReadData;
          cnt_next   = is_write_reg ? 2'd0 : 2'd3;
          state_next = S_RESP;
        end else if (timeout_hit) begin
          resp_next  = {24'd0, RSP_NAK};
          cnt_next   = 2'd0;
          state_next = S_RESP;
        end
      end

      S_RESP: begin
        if (tx_fire) begin
          resp_next = {8'd0, resp_reg[31:8]};
          if (cnt_reg == 2'd0) begin
            state_next = S_IDLE;
          end else begin
            cnt_next = cnt_reg - 2'd1;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_nReset) begin
    if (!i_nReset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= 2'd0;
      is_write_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      resp_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      is_write_reg <= is_write_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      resp_reg     <= resp_next;
    end
  end

endmodule
